muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts two 32-bit operands and a 3-bit M-extension op from the issue/control side.
- Computes the result over multiple cycles while the pipeline stalls on busy.
- Returns a 32-bit result plus a zero flag with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration-counter width; must hold XLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only while busy=0.
- flush  input  1  abort the current operation (pipeline kill).
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data1  input  XLEN  rs1 operand; sampled on an accepted start.
- data2  input  XLEN  rs2 operand; sampled on an accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  final result; held stable until the next accepted start.
- Z  output  1  result==0; updates together with result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, Z=1; all internal registers cleared.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: start=1 and flush=0 -> latch op, data1, data2 -> PREP. While not idle, start is ignored (no queueing).
- PREP (1 cycle):
  - Take the absolute value of each operand treated as signed: data1 for MULH/MULHSU/DIV/REM; data2 for MULH/DIV/REM.
  - Record the result sign: product sign for MUL* ops; quotient sign = s1^s2 and remainder sign = s1 for DIV/REM.
  - Divide by zero (data2==0, any div op): quotient=0xFFFFFFFF, remainder=data1 -> DONE directly.
  - Signed overflow (DIV/REM, data1=0x80000000, data2=0xFFFFFFFF): DIV=0x80000000, REM=0 -> DONE directly.
  - Otherwise load counter=XLEN and clear the 64-bit accumulator -> CALC.
- CALC (exactly XLEN cycles, one bit per cycle):
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; remainder register XLEN+1 bits, quotient shifted in from the LSB.
  - Counter decrements each cycle; when it reaches 0 -> FIX.
- FIX (1 cycle):
  - Apply two's-complement negation per the recorded sign.
  - Select the result: MUL=low 32 bits; MULH/MULHSU/MULHU=high 32 bits; DIV/DIVU=quotient; REM/REMU=remainder.
  - -> DONE.
- DONE (1 cycle): result and Z register, done=1, busy=0 -> IDLE. A new start may be accepted in the cycle after done.
- Latency, counted from the start cycle as cycle 0:
  - Normal ops: done in cycle XLEN+3 (35).
  - Divide by zero and overflow: done in cycle 2.
- busy is high from cycle 1 through the cycle before done.
- flush:
  - Any state other than IDLE -> IDLE next cycle; busy=0; no done pulse; result/Z keep their previous values.
  - flush and start in the same IDLE cycle: flush wins, nothing is accepted.
  - flush in the DONE cycle: done is still asserted in that cycle, because the op has already committed.
- Inputs are not used after PREP; data1/data2 may change freely while busy.
- Async reset mid-operation: return immediately to the reset values; no done pulse.

Decomposition:
- Shared package (muldiv_pkg): XLEN, funct3 op encodings (localparams MD_MUL..MD_REMU), state encoding, DIV0_QUOT=all-ones, SIGNED_MIN=0x80000000.
- One sub-module, muldiv_core: the CALC datapath (shift-add/restoring-step registers plus counter) with load/step/last signals.
- The top level keeps the FSM, sign handling and result selection.

Test Plan:
- MUL 7 x 6 and MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=42 then 0xFFFFFFFE; done in cycle 35; busy high cycles 1-34; Z=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF(-1) x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD(-3); REM -7/2 -> 0xFFFFFFFF(-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same operands -> 0 with Z=1; each done in cycle 2.
- flush in cycle 10 of a DIV -> no done pulse, busy=0 in cycle 11, result unchanged; start in cycle 11 is accepted normally. start asserted while busy -> ignored.
- rst_n low during CALC -> busy=0, done=0, result=0, Z=1 immediately (asynchronously); the next operation completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 6;

    // funct3 encodings of the M extension
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [MD_XLEN-1:0] DIV0_QUOT  = '1;
    localparam logic [MD_XLEN-1:0] SIGNED_MIN = {1'b1, {(MD_XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    // rs1 is interpreted as signed for these ops
    function automatic logic op_signed1(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is interpreted as signed for these ops
    function automatic logic op_signed2(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: radix-2 shift-add multiply or restoring divide, one bit per step.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic                is_div,
    input  logic [XLEN-1:0]     src1,
    input  logic [XLEN-1:0]     src2,
    output logic [2*XLEN-1:0]   prod,
    output logic [XLEN-1:0]     quot,
    output logic [XLEN-1:0]     rem,
    output logic                last
);

    // q holds the multiplier (consumed MSB first) or the dividend/quotient
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   rem_q;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic [XLEN:0]     shifted;
    logic [XLEN-1:0]   diff;
    logic              fits;
    logic [2*XLEN-1:0] addend;
    logic [2*XLEN-1:0] acc_nxt;

    // Next-step values for both the shift-add and the restoring-subtract paths
    always_comb begin
        shifted = {rem_q, q[XLEN-1]};
        fits    = (shifted >= {1'b0, opnd});
        diff    = shifted[XLEN-1:0] - opnd;
        addend  = q[XLEN-1] ? {{XLEN{1'b0}}, opnd} : '0;
        acc_nxt = {acc[2*XLEN-2:0], 1'b0} + addend;
    end

    // Iteration registers: cleared on load, advanced one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd  <= '0;
            q     <= '0;
            rem_q <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            opnd  <= src2;
            q     <= src1;
            rem_q <= '0;
            acc   <= '0;
            cnt   <= CNT_W'(XLEN);
        end else if (step) begin
            cnt <= cnt - 1'b1;
            if (is_div) begin
                rem_q <= fits ? diff : shifted[XLEN-1:0];
                q     <= {q[XLEN-2:0], fits};
            end else begin
                acc <= acc_nxt;
                q   <= {q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign prod = acc;
    assign quot = q;
    assign rem  = rem_q;
    assign last = step && (cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, operand sign handling, special cases and result selection.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic             Z
);

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   d1_q;
    logic [XLEN-1:0]   d2_q;
    logic              neg_q;
    logic              rneg_q;

    logic              s1;
    logic              s2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   early_res;

    logic              core_load;
    logic              core_step;
    logic              calc_last;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    // Operand magnitudes, recorded signs and the divide special cases
    always_comb begin
        s1        = op_signed1(op_q) & d1_q[XLEN-1];
        s2        = op_signed2(op_q) & d2_q[XLEN-1];
        abs1      = s1 ? -d1_q : d1_q;
        abs2      = s2 ? -d2_q : d2_q;
        div_zero  = op_q[2] && (d2_q == '0);
        div_ovf   = op_q[2] && !op_q[0] && (d1_q == SIGNED_MIN) && (d2_q == '1);
        early_res = '0;
        if (div_zero)
            early_res = op_q[1] ? d1_q : DIV0_QUOT;
        else
            early_res = op_q[1] ? '0 : SIGNED_MIN;
    end

    // Sign correction of the unsigned datapath results and funct3 result select
    always_comb begin
        prod_fix = neg_q  ? -prod : prod;
        quot_fix = neg_q  ? -quot : quot;
        rem_fix  = rneg_q ? -rem  : rem;
        fix_res  = '0;
        case (op_q)
            MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = quot_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    assign core_load = (state == ST_PREP);
    assign core_step = (state == ST_CALC);

    muldiv_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_q[2]),
        .src1   (abs1),
        .src2   (abs2),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem),
        .last   (calc_last)
    );

    // Control FSM with registered busy/done/result/Z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            Z      <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        d1_q  <= data1;
                        d2_q  <= data2;
                        busy  <= 1'b1;
                        state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (div_zero || div_ovf) begin
                        result <= early_res;
                        Z      <= (early_res == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        neg_q  <= s1 ^ s2;
                        rneg_q <= s1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (calc_last) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_res;
                        Z      <= (fix_res == '0);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and randomized ops against a plain-arithmetic model.
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
    localparam logic [31:0] MINV = 32'h8000_0000;

    localparam int ND = 12;
    localparam logic [2:0]  TF [ND] = '{F_MUL, F_MULHU, F_MULH, F_MULHSU, F_DIV, F_REM,
                                        F_DIVU, F_REMU, F_DIV, F_REMU, F_DIV, F_REM};
    localparam logic [31:0] TA [ND] = '{32'd7, 32'hFFFF_FFFF, MINV, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                        32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, MINV, MINV};
    localparam logic [31:0] TB [ND] = '{32'd6, 32'hFFFF_FFFF, MINV, 32'd2, 32'd2, 32'd2, 32'd7,
                                        32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    localparam logic [31:0] TE [ND] = '{32'd42, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                                        32'd5, MINV, 32'd0};
    localparam int TL [ND] = '{35, 35, 35, 35, 35, 35, 35, 35, 2, 2, 2, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Z;

    int vectors = 0;
    int errors = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .data1  (data1),
        .data2  (data2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .Z      (Z)
    );

    always #5 clk = ~clk;

    // RV32M semantics from 64-bit products and native integer division
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, b);
        logic [63:0] ua, ub, sa64, sb64, p;
        int sa, sb;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa = a;
        sb = b;
        case (f)
            F_MUL:    begin p = ua * ub;     return p[31:0];  end
            F_MULH:   begin p = sa64 * sb64; return p[63:32]; end
            F_MULHSU: begin p = sa64 * ub;   return p[63:32]; end
            F_MULHU:  begin p = ua * ub;     return p[63:32]; end
            F_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return 32'(sa / sb);
            end
            F_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F_REM: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 2;
        return 35;
    endfunction

    // Start one op in the next cycle and observe until done (bounded); poke re-asserts start while busy
    task automatic issue(input logic [2:0] f, input logic [31:0] a, b, input bit poke,
                         output int lat, output int bc, output logic [31:0] res, output logic z);
        lat = -1;
        bc = 0;
        res = 'x;
        z = 1'bx;
        @(posedge clk); #1;
        start = 1'b1; op = f; data1 = a; data2 = b;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            start = poke;
            op = 3'($urandom);
            data1 = $urandom;
            data2 = $urandom;
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = cyc; res = result; z = Z; start = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (result !== 32'd0 || Z !== 1'b1) begin
            errors++; $display("FAIL reset_result: result=%h Z=%b want 0 1", result, Z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
    endtask

    task automatic test_directed();
        int lat, bc;
        logic [31:0] res;
        logic z;
        for (int i = 0; i < ND; i++) begin
            issue(TF[i], TA[i], TB[i], 1'b0, lat, bc, res, z);
            vectors++;
            if (res !== TE[i] || z !== (TE[i] == 0)) begin
                errors++;
                $display("FAIL directed%0d_result: got %h Z=%b want %h Z=%b", i, res, z, TE[i], TE[i] == 0);
            end
            vectors++;
            if (lat != TL[i] || bc != TL[i] - 1) begin
                errors++;
                $display("FAIL directed%0d_timing: done cycle %0d busy cycles %0d want %0d %0d",
                         i, lat, bc, TL[i], TL[i] - 1);
            end
            last_res = TE[i];
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        logic [31:0] res, exp;
        logic z;
        exp = ref_result(F_DIVU, 32'd1000, 32'd3);
        issue(F_DIVU, 32'd1000, 32'd3, 1'b1, lat, bc, res, z);
        vectors++;
        if (res !== exp || z !== (exp == 0) || lat != 35) begin
            errors++; $display("FAIL busy_start: got %h cycle %0d want %h cycle 35", res, lat, exp);
        end
        last_res = exp;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL no_queue: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_flush();
        int lat, bc;
        bit saw_done;
        logic [31:0] exp;
        // flush and start together: nothing accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = F_MUL; data1 = 32'd3; data2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || result !== last_res) begin
            errors++; $display("FAIL flush_start: busy=%b result=%h want 0 %h", busy, result, last_res);
        end
        // flush in cycle 10 of a DIV, new op started in cycle 11
        @(posedge clk); #1;
        start = 1'b1; op = F_DIV; data1 = 32'hDEAD_0001; data2 = 32'd9;
        saw_done = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = (cyc == 10);
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL flush_c10_busy: busy=%b want 1", busy);
        end
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b1; op = F_MULH; data1 = 32'hFFFF_FFF0; data2 = 32'd5;
        exp = ref_result(F_MULH, 32'hFFFF_FFF0, 32'd5);
        @(negedge clk);
        if (done) saw_done = 1'b1;
        vectors++;
        if (busy !== 1'b0 || saw_done || result !== last_res || Z !== (last_res == 0)) begin
            errors++;
            $display("FAIL flush_abort: busy=%b done_seen=%b result=%h Z=%b want 0 0 %h %b",
                     busy, saw_done, result, Z, last_res, last_res == 0);
        end
        lat = -1; bc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (busy) bc++;
            if (done) begin lat = cyc; break; end
        end
        vectors++;
        if (lat != 35 || bc != 34 || result !== exp) begin
            errors++;
            $display("FAIL flush_restart: cycle %0d busy %0d result %h want 35 34 %h", lat, bc, result, exp);
        end
        last_res = exp;
        // flush in the done cycle: op already committed
        @(posedge clk); #1;
        start = 1'b1; op = F_MULHU; data1 = $urandom; data2 = $urandom;
        exp = ref_result(F_MULHU, data1, data2);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            flush = (cyc == 35);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || result !== exp) begin
            errors++; $display("FAIL flush_in_done: done=%b result=%h want 1 %h", done, result, exp);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        last_res = exp;
    endtask

    task automatic test_random();
        int lat, bc, el;
        logic [31:0] a, b, exp, res;
        logic [2:0] f;
        logic z;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 1000);
                default: ;
            endcase
            exp = ref_result(f, a, b);
            el = ref_latency(f, a, b);
            issue(f, a, b, 1'($urandom_range(0, 1)), lat, bc, res, z);
            vectors++;
            if (res !== exp || z !== (exp == 0)) begin
                errors++;
                $display("FAIL rand%0d_result: op %0d %h,%h got %h Z=%b want %h Z=%b",
                         i, f, a, b, res, z, exp, exp == 0);
            end
            vectors++;
            if (lat != el || bc != el - 1) begin
                errors++;
                $display("FAIL rand%0d_timing: done cycle %0d busy %0d want %0d %0d", i, lat, bc, el, el - 1);
            end
            last_res = exp;
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        logic [31:0] res, exp;
        logic z;
        issue(F_DIVU, 32'd100, 32'd7, 1'b0, lat, bc, res, z);
        vectors++;
        if (res !== 32'd14) begin
            errors++; $display("FAIL pre_reset_op: got %h want 0000000e", res);
        end
        @(posedge clk); #1;
        start = 1'b1; op = F_DIV; data1 = 32'h1234_5678; data2 = 32'd3;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || Z !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%h Z=%b want 0 0 0 1", busy, done, result, Z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = ref_result(F_REM, 32'hFFFF_FF00, 32'd7);
        issue(F_REM, 32'hFFFF_FF00, 32'd7, 1'b0, lat, bc, res, z);
        vectors++;
        if (res !== exp || lat != 35) begin
            errors++; $display("FAIL post_reset_op: got %h cycle %0d want %h cycle 35", res, lat, exp);
        end
        last_res = exp;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
